// File: rtl/button_conditioner.sv
// Button front end: synchronise, debounce, and emit press/release pulses with optional auto-repeat.
// Each channel runs its own debounce counter and repeat FSM; all outputs are registered.
module button_conditioner #(
  parameter int unsigned NUM_BTNS        = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_EN       = 1,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_BTNS-1:0] btn_raw,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [NUM_BTNS-1:0] btn_press,
  output logic [NUM_BTNS-1:0] btn_release
);

  localparam int unsigned DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  logic [NUM_BTNS-1:0] r_s1;
  logic [NUM_BTNS-1:0] r_s2;

  // Two-flop synchroniser, nothing between the stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= btn_raw;
      r_s2 <= r_s1;
    end
  end

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_chan
    logic          r_level;
    logic          r_press;
    logic          r_release;
    logic [DW-1:0] r_dcnt;
    logic [RW-1:0] r_rcnt;
    state_t        r_state;
    logic          w_flip;
    logic          w_rise;
    logic          w_fall;

    assign w_flip = (r_s2[g] != r_level) && (r_dcnt == DW'(DEBOUNCE_CYCLES - 1));
    assign w_rise = w_flip & r_s2[g];
    assign w_fall = w_flip & ~r_s2[g];

    // Debounce: the synced input must disagree for DEBOUNCE_CYCLES consecutive clocks
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_level   <= 1'b0;
        r_dcnt    <= '0;
        r_release <= 1'b0;
      end else begin
        r_release <= w_fall;
        if (r_s2[g] == r_level) begin
          r_dcnt <= '0;
        end else if (w_flip) begin
          r_level <= r_s2[g];
          r_dcnt  <= '0;
        end else begin
          r_dcnt <= r_dcnt + DW'(1);
        end
      end
    end

    // Repeat FSM; a level fall always pre-empts a repeat pulse due that cycle
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= ST_IDLE;
        r_rcnt  <= '0;
        r_press <= 1'b0;
      end else begin
        r_press <= w_rise;
        case (r_state)
          ST_IDLE: begin
            if (w_rise && (REPEAT_EN != 0)) begin
              r_state <= ST_DELAY;
              r_rcnt  <= '0;
            end
          end
          ST_DELAY: begin
            if (w_fall) begin
              r_state <= ST_IDLE;
              r_rcnt  <= '0;
            end else if (r_rcnt == RW'(REPEAT_DELAY - 1)) begin
              r_press <= 1'b1;
              r_rcnt  <= '0;
              r_state <= ST_REPEAT;
            end else begin
              r_rcnt <= r_rcnt + RW'(1);
            end
          end
          ST_REPEAT: begin
            if (w_fall) begin
              r_state <= ST_IDLE;
              r_rcnt  <= '0;
            end else if (r_rcnt == RW'(REPEAT_PERIOD - 1)) begin
              r_press <= 1'b1;
              r_rcnt  <= '0;
            end else begin
              r_rcnt <= r_rcnt + RW'(1);
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_rcnt  <= '0;
          end
        endcase
      end
    end

    assign btn_level[g]   = r_level;
    assign btn_press[g]   = r_press;
    assign btn_release[g] = r_release;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench: two instances (repeat on / off), vector table plus scripted corner cases.
// Expected pulses are queued with their absolute cycle and compared as the cycle arrives.
module tb_button_conditioner;

  logic       clk;
  logic       rst_n;
  logic [2:0] raw   [2];
  logic [2:0] lvl   [2];
  logic [2:0] press [2];
  logic [2:0] rel   [2];
  int         cyc;
  int         n_total;
  int         n_bad;

  typedef struct {
    int         cyc;
    int         dut;
    logic [2:0] lvl;
    logic [2:0] press;
    logic [2:0] rel;
  } ev_t;

  typedef struct {
    logic [2:0] raw;
    int         hold;
    logic [2:0] press;
    logic [2:0] rel;
    logic [2:0] ev_lvl;
    logic [2:0] end_lvl;
  } vec_t;

  ev_t  sb[$];
  vec_t tab[8];

  button_conditioner #(
    .NUM_BTNS(3), .DEBOUNCE_CYCLES(4), .REPEAT_EN(1), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .btn_raw(raw[0]),
    .btn_level(lvl[0]), .btn_press(press[0]), .btn_release(rel[0])
  );

  button_conditioner #(
    .NUM_BTNS(3), .DEBOUNCE_CYCLES(4), .REPEAT_EN(0), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .btn_raw(raw[1]),
    .btn_level(lvl[1]), .btn_press(press[1]), .btn_release(rel[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_ev(input int d, input int c, input logic [2:0] l,
                           input logic [2:0] p, input logic [2:0] r);
    ev_t e;
    int  i;
    e.cyc = c; e.dut = d; e.lvl = l; e.press = p; e.rel = r;
    i = 0;
    while (i < sb.size() && sb[i].cyc <= c) i++;
    sb.insert(i, e);
  endtask

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %b want %b", name, cyc, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard monitor: compare due events, flag any pulse nobody asked for
  always @(negedge clk) begin : mon
    ev_t        e;
    logic [1:0] seen;
    seen = '0;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_total++;
      if (e.cyc != cyc) begin
        n_bad++;
        $display("FAIL missed_event dut%0d: due cyc %0d, now %0d", e.dut, e.cyc, cyc);
      end else begin
        seen[e.dut] = 1'b1;
        if ({lvl[e.dut], press[e.dut], rel[e.dut]} !== {e.lvl, e.press, e.rel}) begin
          n_bad++;
          $display("FAIL event dut%0d @cyc %0d: lvl/press/rel got %b/%b/%b want %b/%b/%b",
                   e.dut, cyc, lvl[e.dut], press[e.dut], rel[e.dut], e.lvl, e.press, e.rel);
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      if (!seen[d] && ((press[d] | rel[d]) != 3'b000)) begin
        n_total++;
        n_bad++;
        $display("FAIL unexpected_pulse dut%0d @cyc %0d: press %b rel %b want 000/000",
                 d, cyc, press[d], rel[d]);
      end
    end
  end

  initial begin
    int c;
    int c2;
    int t0;
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    raw[0]  = 3'b000;
    raw[1]  = 3'b000;

    //          raw    hold press   rel     ev_lvl  end_lvl
    tab[0] = '{3'b001, 8,  3'b001, 3'b000, 3'b001, 3'b001};
    tab[1] = '{3'b000, 8,  3'b000, 3'b001, 3'b000, 3'b000};
    tab[2] = '{3'b010, 3,  3'b000, 3'b000, 3'b000, 3'b000};
    tab[3] = '{3'b000, 8,  3'b000, 3'b000, 3'b000, 3'b000};
    tab[4] = '{3'b010, 4,  3'b010, 3'b000, 3'b010, 3'b000};
    tab[5] = '{3'b000, 10, 3'b000, 3'b010, 3'b000, 3'b000};
    tab[6] = '{3'b101, 8,  3'b101, 3'b000, 3'b101, 3'b101};
    tab[7] = '{3'b000, 8,  3'b000, 3'b101, 3'b000, 3'b000};

    wait_cyc(3);
    check("reset_dut0", {lvl[0], press[0], rel[0]}, 9'd0);
    check("reset_dut1", {lvl[1], press[1], rel[1]}, 9'd0);
    rst_n = 1'b1;
    wait_cyc(2);

    // Vector table: clean press/release, short glitch, minimum-length pulse, two channels at once
    for (int i = 0; i < 8; i++) begin
      c = cyc;
      raw[0] = tab[i].raw;
      if ((tab[i].press | tab[i].rel) != 3'b000)
        expect_ev(0, c + 6, tab[i].ev_lvl, tab[i].press, tab[i].rel);
      wait_cyc(tab[i].hold);
      check($sformatf("tab%0d_level", i), {6'd0, lvl[0]}, {6'd0, tab[i].end_lvl});
    end

    // Long hold on ch2: repeats at +10 then every 5; release lands on a due repeat
    c = cyc;
    t0 = c + 6;
    raw[0] = 3'b100;
    expect_ev(0, t0, 3'b100, 3'b100, 3'b000);
    for (int k = 0; k < 8; k++) expect_ev(0, t0 + 10 + 5 * k, 3'b100, 3'b100, 3'b000);
    wait_cyc(50);
    raw[0] = 3'b000;
    expect_ev(0, t0 + 50, 3'b000, 3'b000, 3'b100);
    wait_cyc(10);

    // Release during DELAY: no repeat pulse
    c = cyc;
    raw[0] = 3'b001;
    expect_ev(0, c + 6, 3'b001, 3'b001, 3'b000);
    wait_cyc(7);
    raw[0] = 3'b000;
    expect_ev(0, c + 13, 3'b000, 3'b000, 3'b001);
    wait_cyc(15);

    // Reset while repeating, button still held afterwards
    c = cyc;
    raw[0] = 3'b001;
    expect_ev(0, c + 6,  3'b001, 3'b001, 3'b000);
    expect_ev(0, c + 16, 3'b001, 3'b001, 3'b000);
    expect_ev(0, c + 21, 3'b001, 3'b001, 3'b000);
    wait_cyc(23);
    check("pre_reset_level", {6'd0, lvl[0]}, 9'b000000001);
    rst_n = 1'b0;
    #1;
    check("mid_hold_reset", {lvl[0], press[0], rel[0]}, 9'd0);
    @(negedge clk);
    rst_n = 1'b1;
    c2 = cyc;
    expect_ev(0, c2 + 6,  3'b001, 3'b001, 3'b000);
    expect_ev(0, c2 + 16, 3'b001, 3'b001, 3'b000);
    expect_ev(0, c2 + 21, 3'b001, 3'b001, 3'b000);
    wait_cyc(17);
    raw[0] = 3'b000;
    expect_ev(0, c2 + 23, 3'b000, 3'b000, 3'b001);
    wait_cyc(12);

    // Repeat disabled: all three held, one press each, same cycle
    c = cyc;
    raw[1] = 3'b111;
    expect_ev(1, c + 6, 3'b111, 3'b111, 3'b000);
    wait_cyc(50);
    check("norepeat_level", {6'd0, lvl[1]}, 9'b000000111);
    raw[1] = 3'b000;
    expect_ev(1, c + 56, 3'b000, 3'b000, 3'b111);
    wait_cyc(12);

    while (sb.size() > 0) begin
      ev_t e;
      e = sb.pop_front();
      n_total++;
      n_bad++;
      $display("FAIL pending_event dut%0d: due cyc %0d never checked", e.dut, e.cyc);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
